// File: rtl/imem_pkg.sv
// ---------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory responder slice:
//   imem_state_e      : responder FSM states (idle / wait states / response)
//   NOP_INST          : instruction returned for misaligned fetches
//   WAIT_CYC_DEFAULT  : default number of wait states between accept and
//                       response
//   CNT_W             : width of the wait-state counter (covers 0..15)
// ---------------------------------------------------------------------------
package imem_pkg;

  localparam int CNT_W = 4;
  localparam int WAIT_CYC_DEFAULT = 2;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

endpackage

// File: rtl/imem_array.sv
// ---------------------------------------------------------------------------
// imem_array
// Word-organised instruction storage, 2^WORD_W x 32 bits.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset (clears the read register only)
//   we_i     : write enable
//   waddr_i  : write word index
//   wdata_i  : write data
//   re_i     : read enable; the read register loads on the clock edge
//   raddr_i  : read word index
//   rdata_o  : registered read data, holds while re_i is low
// A read and a write to the same word on the same edge return the old word.
// ---------------------------------------------------------------------------
module imem_array #(
  parameter int WORD_W = 14
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [WORD_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic              re_i,
  input  logic [WORD_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  localparam int DEPTH = 1 << WORD_W;

  logic [31:0] mem [DEPTH];

  // Storage write port. The array itself is never reset, so program images
  // survive a reset of the responder.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  // Registered read port. Because the write above is also a non-blocking
  // update, a same-edge read sees the contents from before the write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/imem_resp.sv
// ---------------------------------------------------------------------------
// imem_resp
// Target side of the fetch interface: accepts one word fetch at a time,
// returns the instruction WAIT_CYC+1 cycles after the accept cycle, and holds
// the response until the consumer takes it.
//   clk_i, rst_i   : clock (rising edge), asynchronous active-high reset
//   req_valid_i    : fetch request
//   req_addr_i     : byte address of the fetch
//   req_ready_o    : request accepted this cycle when req_valid_i is high
//   rsp_valid_o    : response valid
//   rsp_ready_i    : consumer takes the response
//   rsp_inst_o     : fetched instruction (NOP for a misaligned fetch)
//   rsp_addr_o     : address of the request being answered
//   rsp_err_o      : misaligned fetch
//   busy_o         : transaction outstanding; fetch stage holds its PC
//   flush_i        : redirect; cancels any outstanding transaction
//   ld_we_i, ld_addr_i, ld_data_i : loader write port (word indexed)
// ---------------------------------------------------------------------------
module imem_resp
  import imem_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int WAIT_CYC = WAIT_CYC_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_inst_o,
  output logic [ADDR_W-1:0] rsp_addr_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  input  logic              flush_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-3:0] ld_addr_i,
  input  logic [31:0]       ld_data_i
);

  localparam int WORD_W = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_CYC == 0) ? '0 : CNT_W'(WAIT_CYC - 1);

  imem_state_e       state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic              rsp_valid_q;

  logic              accept;
  logic              enter_resp;
  logic              rd_misaligned;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word;
  logic [31:0]       rd_data;

  // A request is only taken in IDLE, and a redirect in the same cycle wins.
  // The transition into RESP happens either straight from the accept (no
  // wait states) or when the wait counter has run down to zero.
  always_comb begin
    accept     = (state == ST_IDLE) && req_valid_i && !flush_i;
    enter_resp = 1'b0;
    if (!flush_i) begin
      if (state == ST_IDLE) begin
        enter_resp = accept && (WAIT_CYC == 0);
      end else if (state == ST_WAIT) begin
        enter_resp = (wait_cnt == '0);
      end
    end
  end

  // With no wait states the read happens on the accept edge, before the
  // address register is loaded, so the address comes straight from the
  // request port in IDLE and from the latched copy otherwise. Misaligned
  // fetches never touch the array.
  always_comb begin
    if (state == ST_IDLE) begin
      rd_word       = req_addr_i[ADDR_W-1:2];
      rd_misaligned = (req_addr_i[1:0] != 2'b00);
    end else begin
      rd_word       = addr_q[ADDR_W-1:2];
      rd_misaligned = (addr_q[1:0] != 2'b00);
    end
    rd_en = enter_resp && !rd_misaligned;
  end

  imem_array #(
    .WORD_W (WORD_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (ld_we_i),
    .waddr_i (ld_addr_i),
    .wdata_i (ld_data_i),
    .re_i    (rd_en),
    .raddr_i (rd_word),
    .rdata_o (rd_data)
  );

  // Responder FSM with its wait counter and response registers. A flush in
  // any state drops straight back to IDLE and discards the response; a flush
  // coinciding with rsp_ready_i lands in the same place. The error flag is
  // captured only when entering RESP so the response fields change once per
  // transaction and then hold until taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      if (enter_resp) begin
        err_q <= rd_misaligned;
      end
      if (flush_i) begin
        state       <= ST_IDLE;
        wait_cnt    <= '0;
        rsp_valid_q <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req_valid_i) begin
              addr_q <= req_addr_i;
              if (WAIT_CYC == 0) begin
                state       <= ST_RESP;
                rsp_valid_q <= 1'b1;
              end else begin
                wait_cnt <= CNT_LOAD;
                state    <= ST_WAIT;
              end
            end
          end
          ST_WAIT: begin
            if (wait_cnt == '0) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt - CNT_W'(1);
            end
          end
          ST_RESP: begin
            if (rsp_ready_i) begin
              state       <= ST_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end
          default: begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            rsp_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // Output mapping. The accept term of busy_o is combinational so the fetch
  // stage holds its PC in the very cycle its request is taken; it is gated
  // by reset so busy_o reads zero while reset is applied.
  always_comb begin
    req_ready_o = (state == ST_IDLE);
    rsp_valid_o = rsp_valid_q;
    rsp_addr_o  = addr_q;
    rsp_err_o   = err_q;
    rsp_inst_o  = err_q ? NOP_INST : rd_data;
    busy_o      = !rst_i && ((state != ST_IDLE) || accept);
  end

endmodule
